booth_seq_mult: RTL

Sequential, parametrised radix-4 Booth multiplier with a start/done handshake and a run-time approximate mode. It retires one Booth digit per clock, so it processes WIDTH/2 partial products. It is the clocked successor to the team's combinational approximate Booth multiplier and is used wherever a multiply may take several cycles in exchange for area. Signed two's-complement operands produce a full-width 2*WIDTH signed product.

---
 rtl/booth_seq_mult_pkg.sv | 18 +
 rtl/booth_r4_encoder.sv | 29 ++
 rtl/booth_seq_mult.sv | 101 ++++++++++
 3 files changed

// File: rtl/booth_seq_mult_pkg.sv
// Shared encodings for the Booth multipliers: FSM states and radix-4 digit codes.
// Pure typedefs; no logic, no latency, no flow control.
package booth_seq_mult_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        BD_ZERO = 3'd0,
        BD_POS1 = 3'd1,
        BD_POS2 = 3'd2,
        BD_NEG1 = 3'd3,
        BD_NEG2 = 3'd4
    } bd_t;

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: triple (b[2i+1], b[2i], b[2i-1]) -> digit code and negate flag.
// Purely combinational, zero latency; no handshake.
module booth_r4_encoder
    import booth_seq_mult_pkg::*;
(
    input  logic [2:0] triple,
    output bd_t        digit,
    output logic       neg
);

    always_comb begin
        digit = BD_ZERO;
        neg   = 1'b0;
        case (triple)
            3'b001, 3'b010: digit = BD_POS1;
            3'b011:         digit = BD_POS2;
            3'b100: begin
                digit = BD_NEG2;
                neg   = 1'b1;
            end
            3'b101, 3'b110: begin
                digit = BD_NEG1;
                neg   = 1'b1;
            end
            default:        digit = BD_ZERO;
        endcase
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier with optional truncation of each partial product.
// Latency WIDTH/2 cycles from the start edge to done; start is ignored while busy.
module booth_seq_mult
    import booth_seq_mult_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 approx_en,
    input  logic [WIDTH-1:0]     input_A,
    input  logic [WIDTH-1:0]     input_B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   C
);

    localparam int PW   = 2 * WIDTH;
    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(HALF) + 1;
    localparam logic [PW-1:0] LOW_MASK = PW'((64'd1 << APPROX_BITS) - 64'd1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   mcand;
    logic [WIDTH:0]  b_sh;
    logic            approx;
    logic [PW-1:0]   acc;

    bd_t             digit;
    logic            neg;
    logic [PW-1:0]   mag;
    logic [PW-1:0]   pp;
    logic [PW-1:0]   pp_m;
    logic [PW-1:0]   acc_next;

    // b_sh carries an implicit B[-1]=0 in bit 0, so the low triple is always the current digit.
    booth_r4_encoder u_enc (
        .triple (b_sh[2:0]),
        .digit  (digit),
        .neg    (neg)
    );

    // mcand is the sign-extended multiplicand already shifted by 2i for the current digit.
    always_comb begin
        mag = '0;
        case (digit)
            BD_POS1, BD_NEG1: mag = mcand;
            BD_POS2, BD_NEG2: mag = {mcand[PW-2:0], 1'b0};
            default:          mag = '0;
        endcase
        pp       = neg ? (~mag + PW'(1)) : mag;
        pp_m     = approx ? (pp & ~LOW_MASK) : pp;
        acc_next = acc + pp_m;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            C      <= '0;
            acc    <= '0;
            cnt    <= '0;
            mcand  <= '0;
            b_sh   <= '0;
            approx <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{input_A[WIDTH-1]}}, input_A};
                        b_sh   <= {input_B, 1'b0};
                        approx <= approx_en;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_next;
                    mcand <= mcand << 2;
                    b_sh  <= b_sh >> 2;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(HALF - 1)) begin
                        C     <= acc_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
